// File: rtl/uart_pkg.sv
// Purpose: types and constants shared by the UART transmit and receive paths.
// Latency: none, declarations only.
// Backpressure: none.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Purpose: byte-push bus between the UART register logic (master) and the TX serializer (slave).
// Latency: dataWriteAck, txFull and count are registered and reflect the previous edge's push.
// Backpressure: no stall; a push while txFull=1 is dropped and answered with dataWriteAck=0.
// Signals: dataWriteEnable/dataWrite (push request + byte), dataWriteAck (push accepted),
//          txFull (FIFO full), count (FIFO occupancy).
interface uart_tx_serializer_if;
  import uart_pkg::*;

  logic                      dataWriteEnable;
  logic [UART_DATA_BITS-1:0] dataWrite;
  logic                      dataWriteAck;
  logic                      txFull;
  logic [2:0]                count;

  modport master (
    output dataWriteEnable, dataWrite,
    input  dataWriteAck, txFull, count
  );

  modport slave (
    input  dataWriteEnable, dataWrite,
    output dataWriteAck, txFull, count
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Purpose: FIFO_DEPTH-entry byte queue in front of the TX serializer, with push/pop arbitration.
// Latency: a pushed byte is visible at headData and in count after one edge.
// Backpressure: push is dropped when full (pushAck=0); pop is only issued when count>0.
// Ports: clk, reset, pushEnable/pushData, popEnable, headData (oldest entry), pushAck, full, count.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pushEnable,
  input  logic [UART_DATA_BITS-1:0] pushData,
  input  logic                      popEnable,
  output logic [UART_DATA_BITS-1:0] headData,
  output logic                      pushAck,
  output logic                      full,
  output logic [CNT_W-1:0]          count
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  logic [UART_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wrPtr;
  logic [PTR_W-1:0]          rdPtr;
  logic [CNT_W-1:0]          countNext;
  logic                      pushOk;

  // Acceptance looks at the pre-edge count only, so a push racing a pop
  // while full is still rejected.
  assign pushOk   = pushEnable && (count != FULL_COUNT);
  assign headData = mem[rdPtr];

  always_comb begin
    countNext = count;
    if (pushOk && !popEnable) begin
      countNext = count + CNT_W'(1);
    end else if (!pushOk && popEnable) begin
      countNext = count - CNT_W'(1);
    end
  end

  // Storage carries no reset; entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (pushOk) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      full    <= 1'b0;
      pushAck <= 1'b0;
    end else begin
      pushAck <= pushOk;
      count   <= countNext;
      full    <= (countNext == FULL_COUNT);
      if (pushOk) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (popEnable) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// Purpose: UART transmitter; queues bytes and sends each as an 8N1 frame (start, 8 data LSB first, stop).
// Latency: push accepted at edge N on an idle block -> tx falls after edge N+1; frame = 10*CLKS_PER_BIT cycles.
// Backpressure: pushes beyond FIFO_DEPTH are dropped with dataWriteAck=0; queued frames go out back-to-back.
// Ports: clk, reset (sync, active high), bus (push interface, slave side), busy (frame or data pending), tx (serial line).
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_serializer_if.slave  bus,
  output logic                 busy,
  output logic                 tx
);

  localparam int          CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_LAST   = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT    = 3'(UART_DATA_BITS - 1);
  localparam logic        START_LEVEL = ~UART_IDLE_LEVEL;

  uart_tx_state_t            state;
  uart_tx_state_t            stateNext;
  logic [15:0]               baudCnt;
  logic [15:0]               baudNext;
  logic [2:0]                bitCnt;
  logic [2:0]                bitNext;
  logic [UART_DATA_BITS-1:0] shiftReg;
  logic [UART_DATA_BITS-1:0] shiftNext;
  logic [UART_DATA_BITS-1:0] headData;
  logic                      txReg;
  logic                      txNext;
  logic                      pop;
  logic                      baudDone;
  logic [CNT_W-1:0]          fifoCount;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) fifo (
    .clk        (clk),
    .reset      (reset),
    .pushEnable (bus.dataWriteEnable),
    .pushData   (bus.dataWrite),
    .popEnable  (pop),
    .headData   (headData),
    .pushAck    (bus.dataWriteAck),
    .full       (bus.txFull),
    .count      (fifoCount)
  );

  assign bus.count = 3'(fifoCount);
  assign baudDone  = (baudCnt == BAUD_LAST);

  // State register, together with the datapath registers the FSM steers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      txReg    <= UART_IDLE_LEVEL;
    end else begin
      state    <= stateNext;
      baudCnt  <= baudNext;
      bitCnt   <= bitNext;
      shiftReg <= shiftNext;
      txReg    <= txNext;
    end
  end

  // Next-state logic. tx is computed one edge ahead so the pin is driven
  // straight from a flop.
  always_comb begin
    stateNext = state;
    baudNext  = baudCnt + 16'd1;
    bitNext   = bitCnt;
    shiftNext = shiftReg;
    txNext    = txReg;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        baudNext = '0;
        txNext   = UART_IDLE_LEVEL;
        if (fifoCount != '0) begin
          pop       = 1'b1;
          shiftNext = headData;
          txNext    = START_LEVEL;
          stateNext = START;
        end
      end
      START: begin
        if (baudDone) begin
          baudNext  = '0;
          bitNext   = '0;
          txNext    = shiftReg[0];
          stateNext = DATA;
        end
      end
      DATA: begin
        if (baudDone) begin
          baudNext = '0;
          if (bitCnt == LAST_BIT) begin
            txNext    = UART_IDLE_LEVEL;
            stateNext = STOP;
          end else begin
            shiftNext = shiftReg >> 1;
            bitNext   = bitCnt + 3'd1;
            txNext    = shiftReg[1];
          end
        end
      end
      STOP: begin
        if (baudDone) begin
          baudNext = '0;
          // A waiting byte starts on the very next cycle: no idle gap between frames.
          if (fifoCount != '0) begin
            pop       = 1'b1;
            shiftNext = headData;
            txNext    = START_LEVEL;
            stateNext = START;
          end else begin
            txNext    = UART_IDLE_LEVEL;
            stateNext = IDLE;
          end
        end
      end
      default: begin
        stateNext = IDLE;
        baudNext  = '0;
        txNext    = UART_IDLE_LEVEL;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    tx   = txReg;
    busy = (state != IDLE) || (fifoCount != '0);
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic tx;

  uart_tx_serializer_if bus();

  uart_tx_serializer #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a byte queue plus the edge at which the current frame
  // began. A pop happens on the first edge, at least one frame after the
  // previous pop, at which bytes are waiting; the line level follows from the
  // offset into that frame.
  int         cyc      = 0;
  logic [7:0] q[$];
  int         nextPop  = 0;
  bit         havePop  = 0;
  int         popEdge  = 0;
  logic [7:0] curByte  = 8'h00;
  bit         mAck     = 0;

  // Line decoder: samples mid-bit after each falling edge and collects bytes.
  bit         rxActive = 0;
  int         rxCnt    = 0;
  logic [7:0] rxShift  = 8'h00;
  logic [7:0] rxQ[$];

  typedef struct {
    bit         en;
    logic [7:0] d;
    bit         expAck;
    int         expCount;
    bit         expFull;
  } vec_t;

  vec_t ovf[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic modelTx();
    int off;
    int bitIdx;
    if (!havePop) return 1'b1;
    off = cyc - popEdge;
    if (off >= FRAME) return 1'b1;
    bitIdx = off / CPB;
    if (bitIdx == 0) return 1'b0;
    if (bitIdx == 9) return 1'b1;
    return curByte[bitIdx-1];
  endfunction

  task automatic step(input bit en, input logic [7:0] d, input bit rst);
    int  pre;
    bit  pop;
    bit  acc;
    int  k;
    bit  expBusy;
    bus.dataWriteEnable = en;
    bus.dataWrite       = d;
    reset               = rst;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      havePop = 0;
      nextPop = 0;
      mAck    = 0;
    end else begin
      pre = q.size();
      pop = (cyc >= nextPop) && (pre > 0);
      acc = en && (pre < 4);
      if (pop) begin
        curByte = q.pop_front();
        popEdge = cyc;
        nextPop = cyc + FRAME;
        havePop = 1;
      end
      if (acc) q.push_back(d);
      mAck = acc;
    end
    #1;
    expBusy = (havePop && (cyc - popEdge < FRAME)) || (q.size() != 0);
    check("tx",     32'(tx),               32'(modelTx()));
    check("ack",    32'(bus.dataWriteAck), 32'(mAck));
    check("count",  32'(bus.count),        32'(q.size()));
    check("txFull", 32'(bus.txFull),       32'(q.size() == 4));
    check("busy",   32'(busy),             32'(expBusy));
    if (!rxActive) begin
      if (tx === 1'b0) begin
        rxActive = 1;
        rxCnt    = 0;
      end
    end else begin
      rxCnt++;
    end
    if (rxActive && (rxCnt % CPB == CPB / 2)) begin
      k = rxCnt / CPB;
      if (k >= 1 && k <= 8) rxShift[k-1] = tx;
      if (k == 9) begin
        rxActive = 0;
        if (tx === 1'b1) rxQ.push_back(rxShift);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int a5Bits[10];
    int firstPop;
    int e;
    int p;
    int low;
    int rate;
    logic [7:0] v;

    a5Bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    ovf[0] = '{1'b1, 8'h01, 1'b1, 1, 1'b0};
    ovf[1] = '{1'b1, 8'h02, 1'b1, 1, 1'b0};
    ovf[2] = '{1'b1, 8'h03, 1'b1, 2, 1'b0};
    ovf[3] = '{1'b1, 8'h04, 1'b1, 3, 1'b0};
    ovf[4] = '{1'b1, 8'h05, 1'b1, 4, 1'b1};
    ovf[5] = '{1'b1, 8'h06, 1'b0, 4, 1'b1};

    // Reset state.
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("rst_tx",    32'(tx),               32'd1);
    check("rst_ack",   32'(bus.dataWriteAck), 32'd0);
    check("rst_count", 32'(bus.count),        32'd0);
    check("rst_full",  32'(bus.txFull),       32'd0);
    check("rst_busy",  32'(busy),             32'd0);

    // Single byte 0xA5.
    idle(3);
    step(1'b1, 8'hA5, 1'b0);
    check("a5_ack",       32'(bus.dataWriteAck), 32'd1);
    check("a5_tx_before", 32'(tx),               32'd1);
    for (int k = 0; k < FRAME; k++) begin
      step(1'b0, 8'h00, 1'b0);
      check("a5_bit",  32'(tx),   32'(a5Bits[k / CPB]));
      check("a5_busy", 32'(busy), 32'd1);
    end
    step(1'b0, 8'h00, 1'b0);
    check("a5_busy_end", 32'(busy), 32'd0);
    check("a5_tx_end",   32'(tx),   32'd1);

    // Overflow, then push into a full FIFO on the final stop cycle.
    idle(3);
    rxQ.delete();
    firstPop = 0;
    for (int i = 0; i < 6; i++) begin
      step(ovf[i].en, ovf[i].d, 1'b0);
      if (i == 1) firstPop = cyc;
      check("ovf_ack",   32'(bus.dataWriteAck), 32'(ovf[i].expAck));
      check("ovf_count", 32'(bus.count),        32'(ovf[i].expCount));
      check("ovf_full",  32'(bus.txFull),       32'(ovf[i].expFull));
    end
    while (cyc < firstPop + FRAME - 1) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h77, 1'b0);
    check("full_pushpop_ack",   32'(bus.dataWriteAck), 32'd0);
    check("full_pushpop_count", 32'(bus.count),        32'd3);
    check("full_pushpop_full",  32'(bus.txFull),       32'd0);
    while (cyc < firstPop + 5 * FRAME - 1) step(1'b0, 8'h00, 1'b0);
    check("ovf_busy_last", 32'(busy), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    check("ovf_busy_done", 32'(busy), 32'd0);
    idle(2);
    check("ovf_rx_count", 32'(rxQ.size()), 32'd5);
    for (int i = 0; i < 5 && i < rxQ.size(); i++) check("ovf_rx_byte", 32'(rxQ[i]), 32'(i + 1));

    // Mid-frame refill.
    idle(5);
    rxQ.delete();
    step(1'b1, 8'h11, 1'b0);
    e = cyc;
    while (cyc < e + 16) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    check("refill_ack",   32'(bus.dataWriteAck), 32'd1);
    check("refill_count", 32'(bus.count),        32'd1);
    while (cyc < e + FRAME) step(1'b0, 8'h00, 1'b0);
    check("refill_stop",  32'(tx), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    check("refill_start", 32'(tx), 32'd0);
    idle(45);
    check("refill_rx_count", 32'(rxQ.size()), 32'd2);
    if (rxQ.size() == 2) begin
      check("refill_rx_0", 32'(rxQ[0]), 32'h11);
      check("refill_rx_1", 32'(rxQ[1]), 32'h3C);
    end

    // Reset during data bit 3 with two bytes queued.
    idle(3);
    step(1'b1, 8'h5A, 1'b0);
    p = cyc + 1;
    step(1'b1, 8'h66, 1'b0);
    step(1'b1, 8'h99, 1'b0);
    check("midrst_queued", 32'(bus.count), 32'd2);
    while (cyc < p + 4 * CPB + 1) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("midrst_tx",    32'(tx),        32'd1);
    check("midrst_count", 32'(bus.count), 32'd0);
    check("midrst_busy",  32'(busy),      32'd0);
    low = 0;
    repeat (60) begin
      step(1'b0, 8'h00, 1'b0);
      if (tx !== 1'b1) low++;
    end
    check("midrst_no_frames", 32'(low), 32'd0);

    // Pointer wrap: 9 bytes in bursts of 3.
    rxQ.delete();
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < 3; j++) begin
        v = 8'(16 + 3 * b + j);
        step(1'b1, v, 1'b0);
      end
      idle(130);
    end
    check("wrap_rx_count", 32'(rxQ.size()), 32'd9);
    for (int i = 0; i < 9 && i < rxQ.size(); i++) check("wrap_rx_byte", 32'(rxQ[i]), 32'(16 + i));

    // Randomized traffic with occasional resets, at several push rates.
    for (int blk = 0; blk < 8; blk++) begin
      case (blk % 4)
        0: rate = 1;
        1: rate = 5;
        2: rate = 30;
        default: rate = 90;
      endcase
      repeat (400) begin
        step($urandom_range(0, 99) < rate, 8'($urandom), $urandom_range(0, 599) == 0);
      end
    end
    idle(200);
    check("final_idle_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit half of the UART path; the counterpart to the receive-side ring buffer.
- The CPU/bus side pushes bytes into a 4-entry FIFO.
- The block serializes each byte onto the tx line as an 8N1 frame: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Sits between the memory-mapped UART register logic and the board TX pin.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit time (50 MHz / 115200); legal range 2..65535
FIFO_DEPTH, 4, byte entries; must be a power of two

Ports:
clk  input  1  global clock
reset  input  1  synchronous, active-high reset
dataWriteEnable  input  1  request to push dataWrite into the FIFO
dataWrite  input  8  byte to transmit
dataWriteAck  output  1  registered; 1 for one cycle after an accepted push, 0 after a rejected push
txFull  output  1  FIFO holds FIFO_DEPTH bytes
busy  output  1  frame in progress or FIFO non-empty
count  output  3  current FIFO occupancy, 0..FIFO_DEPTH
tx  output  1  serial line, idle high

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is synchronous and active-high, sampled on the rising clk edge.
- Reset values:
  - tx=1, dataWriteAck=0, txFull=0, busy=0, count=0.
  - FIFO read/write pointers = 0; state = IDLE; bit counter = 0; baud counter = 0.
- Reset mid-frame: the frame is abandoned, tx=1 after the edge, and all queued bytes are discarded.
- FIFO push:
  - Accepted when dataWriteEnable=1 and count<FIFO_DEPTH, evaluated on pre-edge count.
  - An accepted push writes the entry at wrPtr, increments wrPtr modulo depth, and sets dataWriteAck=1.
  - When full, the byte is dropped, no state changes, and dataWriteAck=0.
  - A push and pop on the same edge with count=FIFO_DEPTH: the push is rejected; count becomes FIFO_DEPTH-1.
  - A push and pop on the same edge with 0<count<FIFO_DEPTH: count is unchanged.
  - A pop never occurs with count=0.
- Serializer state machine. State set: IDLE, START, DATA, STOP. A baud counter counts 0..CLKS_PER_BIT-1.
  - IDLE: tx=1. If count>0: pop the FIFO head into the shift register, tx<=0, baud counter<=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles. At terminal count: tx<=shift[0], bit counter<=0, go to DATA.
  - DATA: at each terminal count, shift right and increment the bit counter. After bit 7 completes: tx<=1, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At terminal count:
    - if count>0, pop, tx<=0, go to START (back-to-back frames, zero idle gap);
    - else go to IDLE.
- Latency:
  - Push accepted at edge N with the block idle and the FIFO empty → tx falls after edge N+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- Derived outputs:
  - busy = (state!=IDLE) || (count!=0).
  - txFull = (count==FIFO_DEPTH), registered together with count.
- Width and wrap rules:
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - count is a separate register; full/empty never derive from pointer equality.
  - Baud counter width is 16 bits.

Decomposition:
- Package uart_pkg:
  - typedef uart_tx_state_t {IDLE, START, DATA, STOP};
  - constants UART_DATA_BITS=8 and UART_IDLE_LEVEL=1'b1.
  - Shared with the receive side.
- Sub-module uart_tx_fifo:
  - Contains storage, pointers, count, full logic and the push/pop arbitration.
  - The top module holds the state machine, baud counter and shift register.

Test Plan (CLKS_PER_BIT=4):
- Single byte: push 0xA5 while idle.
  - Required: tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, 40 cycles total.
  - Required: tx falls exactly 1 cycle after the ack edge; busy returns to 0 after the stop bit.
- Overflow: push 0x01..0x06 on 6 consecutive cycles from idle.
  - Required: 0x01..0x05 acked, 0x06 gets dataWriteAck=0.
  - Required: count peaks at 4 with txFull=1; 5 frames are sent back-to-back in 200 cycles with no high gap between stop and start bits.
- Simultaneous full push/pop: hold the FIFO full and push 0x77 on the final STOP cycle of the frame.
  - Required: 0x77 rejected (ack=0), count goes 4→3.
- Mid-frame refill: push 0x3C during DATA of the previous frame with count=0.
  - Required: ack=1, count=1; 0x3C's start bit immediately follows the previous stop bit.
- Reset mid-frame: assert reset for 1 cycle during bit 3 of a frame with 2 bytes queued.
  - Required: tx=1, count=0, busy=0 on the next cycle; no further frames.
- Wrap-around: push and transmit 9 bytes 0x10..0x18 in bursts of 3.
  - Required: pointers wrap twice and the bytes are received in order with no corruption.
